cellram_async_ctrl: RTL and testbench

// - Initiator side of the CellularRAM pin interface: drives the Nexys2 Micron

---
 rtl/cellram_async_ctrl_if.sv | 15 +
 rtl/cellram_async_ctrl.sv | 149 ++++++++++++++
 tb/tb_cellram_async_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cellram_async_ctrl_if.sv
// User-side request/acknowledge bus of the asynchronous CellularRAM controller.
// The user logic takes the master modport and the controller takes the slave modport.
interface cellram_async_ctrl_if;
    logic        req;
    logic        we;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be_n;
    logic        ack;
    logic [15:0] rdata;
    logic        busy;

    modport master (output req, we, addr, wdata, be_n, input ack, rdata, busy);
    modport slave  (input req, we, addr, wdata, be_n, output ack, rdata, busy);
endinterface

// File: rtl/cellram_async_ctrl.sv
// Asynchronous-mode CellularRAM initiator: single-word req/ack accesses become timed CS/OE/WR pin sequences.
// Define CELLRAM_BCR_INIT_EN to write BCR_VALUE into the bus configuration register after every reset.
module cellram_async_ctrl #(
    parameter int          RD_CYCLES = 4,
    parameter int          WR_CYCLES = 4,
    parameter int          RECOV     = 1,
    parameter logic [22:0] BCR_VALUE = 23'h01_1D1F
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cellram_async_ctrl_if.slave  bus,
    output logic [22:0]          MemAdr,
    inout  wire  [15:0]          MemDB,
    output logic                 MemOE,
    output logic                 MemWR,
    output logic                 RamAdv,
    output logic                 RamCRE,
    output logic                 RamCS,
    output logic                 RamClk,
    output logic                 RamLB,
    output logic                 RamUB,
    input  logic                 RamWait
);

    localparam int CntMax = (RD_CYCLES > WR_CYCLES)
                          ? ((RD_CYCLES > RECOV) ? RD_CYCLES : RECOV)
                          : ((WR_CYCLES > RECOV) ? WR_CYCLES : RECOV);
    localparam int CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] RdLoad  = CntW'(RD_CYCLES - 1);
    localparam logic [CntW-1:0] WrLoad  = CntW'(WR_CYCLES - 1);
    localparam logic [CntW-1:0] RecLoad = CntW'(RECOV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE,
        RECOVERY
`ifdef CELLRAM_BCR_INIT_EN
        , CFG
`endif
    } stateT;

`ifdef CELLRAM_BCR_INIT_EN
    localparam stateT ResetState = CFG;
`else
    localparam stateT ResetState = IDLE;
`endif

    stateT           state, nextState;
    logic [CntW-1:0] cnt;
    logic            weReg;
    logic [15:0]     wdataReg;
    logic [1:0]      beReg;
    logic [15:0]     rdataReg;
    logic            cfgPhase;
    logic            driveDb;
    logic            byteWindow;
    logic            unusedInputs;

    // The wait pin only matters in synchronous burst mode.
    assign unusedInputs = ^{RamWait, BCR_VALUE};

    // State register; an asynchronous reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ResetState;
        else        state <= nextState;
    end

    // Next-state logic; both ACCESS and RECOVERY leave once the shared counter reaches zero.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (bus.req) nextState = SETUP;
            SETUP:    nextState = ACCESS;
            ACCESS:   if (cnt == '0) nextState = DONE;
            DONE:     nextState = RECOVERY;
            RECOVERY: if (cnt == '0) nextState = IDLE;
`ifdef CELLRAM_BCR_INIT_EN
            CFG:      nextState = SETUP;
`endif
            default:  nextState = IDLE;
        endcase
    end

    // Shared down-counter: strobe length is loaded in SETUP, recovery length in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (state == SETUP)     cnt <= weReg ? WrLoad : RdLoad;
        else if (state == DONE)      cnt <= RecLoad;
        else if (cnt != '0)          cnt <= cnt - CntW'(1);
    end

    // Request capture and read-data latch; read data is taken on the edge that leaves ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weReg    <= 1'b0;
            wdataReg <= '0;
            beReg    <= 2'b11;
            MemAdr   <= '0;
            rdataReg <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                weReg    <= bus.we;
                wdataReg <= bus.wdata;
                beReg    <= bus.be_n;
                MemAdr   <= bus.addr;
            end
`ifdef CELLRAM_BCR_INIT_EN
            if (state == CFG) begin
                weReg    <= 1'b1;
                wdataReg <= '0;
                beReg    <= 2'b00;
                MemAdr   <= BCR_VALUE;
            end
`endif
            if (state == ACCESS && !weReg && cnt == '0) rdataReg <= MemDB;
        end
    end

`ifdef CELLRAM_BCR_INIT_EN
    // The configuration write is flagged until its recovery period ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                cfgPhase <= 1'b1;
        else if (state == RECOVERY && cnt == '0)   cfgPhase <= 1'b0;
    end
`else
    assign cfgPhase = 1'b0;
`endif

    // Pin decode; write data stays on the bus through DONE to cover data hold after WR rises.
    assign driveDb    = weReg && (state == ACCESS || state == DONE);
    assign byteWindow = (state == SETUP) || (state == ACCESS) || (state == DONE);

    assign RamCS  = !(state == SETUP || state == ACCESS);
    assign MemOE  = !(state == ACCESS && !weReg);
    assign MemWR  = !(state == ACCESS && weReg);
    assign MemDB  = driveDb ? wdataReg : 16'hzzzz;
    assign RamLB  = byteWindow ? beReg[0] : 1'b1;
    assign RamUB  = byteWindow ? beReg[1] : 1'b1;
    assign RamCRE = cfgPhase && byteWindow;
    assign RamAdv = 1'b0;
    assign RamClk = 1'b0;

    assign bus.ack   = (state == DONE) && !cfgPhase;
    assign bus.busy  = (state != IDLE);
    assign bus.rdata = rdataReg;

endmodule

// File: tb/tb_cellram_async_ctrl.sv
// Directed self-checking bench for cellram_async_ctrl with a small behavioural CellularRAM model.
// Define CELLRAM_BCR_INIT_EN to exercise the post-reset configuration write instead of the idle reset checks.
module tb_cellram_async_ctrl;

    localparam logic [22:0] BcrValue = 23'h01_1D1F;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        RamWait = 1'b0;
    wire  [15:0] MemDB;
    logic [22:0] MemAdr;
    logic        MemOE, MemWR, RamAdv, RamCRE, RamCS, RamClk, RamLB, RamUB;

    int checks = 0;
    int errors = 0;

    cellram_async_ctrl_if bus();

    cellram_async_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .MemAdr  (MemAdr),
        .MemDB   (MemDB),
        .MemOE   (MemOE),
        .MemWR   (MemWR),
        .RamAdv  (RamAdv),
        .RamCRE  (RamCRE),
        .RamCS   (RamCS),
        .RamClk  (RamClk),
        .RamLB   (RamLB),
        .RamUB   (RamUB),
        .RamWait (RamWait)
    );

    always #10 clk = ~clk;

    // RAM model: a write commits only if WR was held low for the full pulse width.
    logic [15:0] mem [256] = '{default: 16'h0000};
    int          wrRun = 0;
    int          overlaps = 0;
    logic [7:0]  wrAdr;
    logic [15:0] wrData;
    logic [1:0]  wrBe;

    assign MemDB = (!RamCS && !MemOE) ? mem[MemAdr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!MemOE && !MemWR) overlaps <= overlaps + 1;
        if (!RamCS && !MemWR && !RamCRE) begin
            wrRun  <= wrRun + 1;
            wrAdr  <= MemAdr[7:0];
            wrData <= MemDB;
            wrBe   <= {RamUB, RamLB};
        end else begin
            if (wrRun >= 4) begin
                if (!wrBe[0]) mem[wrAdr][7:0]  <= wrData[7:0];
                if (!wrBe[1]) mem[wrAdr][15:8] <= wrData[15:8];
            end
            wrRun <= 0;
        end
    end

    int          lat, strobe;
    logic [15:0] rd;
    logic [22:0] adrSeen;
    int          ackCount, ack1, ack2, csCount, cs1, cs2;
    logic        prevCs, ackSeen, firstCre, gotCs;
    logic [22:0] firstAdr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One request pulse, then watch cycles 1..40 after the sampling edge for the strobe and ack.
    task automatic applyStimulus(input logic w, input logic [22:0] a, input logic [15:0] d,
                                 input logic [1:0] b, output int latency, output int strobeLow,
                                 output logic [15:0] rdOut, output logic [22:0] adrOut);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be_n = b;
        latency = 0; strobeLow = 0; rdOut = '0; adrOut = '0;
        @(posedge clk); @(negedge clk);
        bus.req = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if ((w && !MemWR) || (!w && !MemOE)) begin
                strobeLow++;
                adrOut = MemAdr;
            end
            if (bus.ack) begin
                latency = n;
                rdOut   = bus.rdata;
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        for (int n = 0; n < 30 && bus.busy; n++) begin
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be_n = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

`ifdef CELLRAM_BCR_INIT_EN
        checkOutput("cfgBusyAtReset", 32'(bus.busy), 1);
        gotCs = 1'b0; firstCre = 1'b0; firstAdr = '0; ack1 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 2) begin
                bus.req = 1'b1; bus.we = 1'b0; bus.addr = 23'h000042; bus.be_n = 2'b00;
            end
            if (!RamCS && !gotCs) begin
                gotCs    = 1'b1;
                firstCre = RamCRE;
                firstAdr = MemAdr;
            end
            if (n == 7) checkOutput("cfgBusyInRecov", 32'(bus.busy), 1);
            if (bus.ack) begin
                ack1 = n;
                break;
            end
        end
        bus.req = 1'b0;
        checkOutput("cfgFirstCre", 32'(firstCre), 1);
        checkOutput("cfgFirstAdr", 32'(firstAdr), 32'(BcrValue));
        checkOutput("cfgHeldReqAck", ack1, 14);
        for (int n = 0; n < 30 && bus.busy; n++) begin
            @(posedge clk); @(negedge clk);
        end
`else
        ackSeen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (bus.ack) ackSeen = 1'b1;
        end
        checkOutput("idleBusy",   32'(bus.busy), 0);
        checkOutput("idleAck",    32'(ackSeen),  0);
        checkOutput("idleCs",     32'(RamCS),    1);
        checkOutput("idleOe",     32'(MemOE),    1);
        checkOutput("idleWr",     32'(MemWR),    1);
        checkOutput("idleLbUb",   32'({RamUB, RamLB}), 32'h3);
        checkOutput("idleAdvClk", 32'({RamAdv, RamClk}), 0);
        checkOutput("idleCre",    32'(RamCRE),   0);
        checkOutput("idleAdr",    32'(MemAdr),   0);
        checkOutput("idleRdata",  32'(bus.rdata), 0);
`endif

        applyStimulus(1'b1, 23'h000123, 16'hBEEF, 2'b00, lat, strobe, rd, adrSeen);
        checkOutput("wrLatency", lat, 6);
        checkOutput("wrPulse", strobe, 4);
        applyStimulus(1'b0, 23'h000123, 16'h0000, 2'b00, lat, strobe, rd, adrSeen);
        checkOutput("rdLatency", lat, 6);
        checkOutput("rdPulse", strobe, 4);
        checkOutput("rdBeef", 32'(rd), 32'hBEEF);

        applyStimulus(1'b1, 23'h000123, 16'h1234, 2'b10, lat, strobe, rd, adrSeen);
        checkOutput("wrLowByteLatency", lat, 6);
        applyStimulus(1'b0, 23'h000123, 16'h0000, 2'b00, lat, strobe, rd, adrSeen);
        checkOutput("rdMerged", 32'(rd), 32'hBE34);

        applyStimulus(1'b1, 23'h7FFFFF, 16'hABCD, 2'b00, lat, strobe, rd, adrSeen);
        checkOutput("topAdrSeen", 32'(adrSeen), 32'h7FFFFF);
        checkOutput("rdataHeldOverWrite", 32'(bus.rdata), 32'hBE34);
        applyStimulus(1'b0, 23'h7FFFFF, 16'h0000, 2'b00, lat, strobe, rd, adrSeen);
        checkOutput("rdTopAdr", 32'(rd), 32'hABCD);

        applyStimulus(1'b1, 23'h000123, 16'h0000, 2'b11, lat, strobe, rd, adrSeen);
        checkOutput("noByteLatency", lat, 6);
        checkOutput("noBytePulse", strobe, 4);
        applyStimulus(1'b0, 23'h000123, 16'h0000, 2'b00, lat, strobe, rd, adrSeen);
        checkOutput("noByteUnchanged", 32'(rd), 32'hBE34);

        // Back-to-back reads with req held high across the first ack.
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 23'h000123; bus.be_n = 2'b00;
        ackCount = 0; ack1 = 0; ack2 = 0; csCount = 0; cs1 = 0; cs2 = 0; prevCs = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int n = 1; n <= 40; n++) begin
            if (!RamCS && prevCs) begin
                csCount++;
                if (csCount == 1) cs1 = n;
                else if (csCount == 2) cs2 = n;
            end
            prevCs = RamCS;
            if (bus.ack) begin
                ackCount++;
                if (ackCount == 1) ack1 = n;
                else begin
                    ack2 = n;
                    bus.req = 1'b0;
                    break;
                end
            end
            @(posedge clk); @(negedge clk);
        end
        bus.req = 1'b0;
        checkOutput("b2bFirstSetup", cs1, 1);
        checkOutput("b2bFirstAck", ack1, 6);
        checkOutput("b2bSecondSetup", cs2, 9);
        checkOutput("b2bSecondAck", ack2, 14);
        for (int n = 0; n < 30 && bus.busy; n++) begin
            @(posedge clk); @(negedge clk);
        end
        checkOutput("oeWrOverlap", overlaps, 0);

        // Reset pulse during the write strobe must abort the access.
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 23'h000123; bus.wdata = 16'h5555; bus.be_n = 2'b00;
        @(posedge clk); @(negedge clk);
        bus.req = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("abortWrLowBefore", 32'(MemWR), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("abortCs", 32'(RamCS), 1);
        checkOutput("abortWr", 32'(MemWR), 1);
        checkOutput("abortAck", 32'(bus.ack), 0);
        checkOutput("abortRdata", 32'(bus.rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 30 && bus.busy; n++) begin
            @(posedge clk); @(negedge clk);
        end
        applyStimulus(1'b0, 23'h000123, 16'h0000, 2'b00, lat, strobe, rd, adrSeen);
        checkOutput("abortKeepsOld", 32'(rd), 32'hBE34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
